// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - EX stage pipeline-facing bus bundle
//
// Groups every non-clock/reset signal of ex_stage.
//   stall           [5:0]   pipeline stall vector (1 = stop); bit 2 ID/EX, bit 3 EX/MEM
//   id_to_ex_bus    [158:0] decode-stage payload
//   ex_to_mem_bus   [75:0]  payload to the memory stage
//   ex_to_id_bus    [37:0]  forwarding to decode {rf_we, rf_waddr, ex_result}
//   data_sram_*             data RAM request
//   stallreq_for_ex         stall request while the divider is busy
// Modports: slave = ex_stage, master = surrounding pipeline / testbench.
interface ex_stage_if;
    logic [5:0]   stall;
    logic [158:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_id_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         stallreq_for_ex;

    modport slave (
        input  stall, id_to_ex_bus,
        output ex_to_mem_bus, ex_to_id_bus, data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata, stallreq_for_ex
    );

    modport master (
        output stall, id_to_ex_bus,
        input  ex_to_mem_bus, ex_to_id_bus, data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata, stallreq_for_ex
    );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ID/EX register, ALU, HI/LO, iterative divider
//
// Ports:
//   clk  pipeline clock
//   rst  asynchronous active-low reset
//   bus  ex_stage_if.slave (stall vector, id_to_ex_bus in; ex_to_mem_bus,
//        ex_to_id_bus, data SRAM request, stallreq_for_ex out)
// Optional feature: define EX_MULT_EN to enable single-cycle MULT/MULTU;
// without it MULT/MULTU leave HI/LO untouched and no multiplier exists.
module ex_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   bus
);
    localparam logic STOP = 1'b1;

    // ID/EX pipeline register
    logic [158:0] id_ex_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex_q <= '0;
        end else if (bus.stall[2] == STOP && bus.stall[3] != STOP) begin
            id_ex_q <= '0;
        end else if (bus.stall[2] != STOP) begin
            id_ex_q <= bus.id_to_ex_bus;
        end
    end

    logic [31:0] ex_pc, inst, rdata1, rdata2;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic [3:0]  sel_alu_src2;
    logic        data_ram_en, rf_we, sel_rf_res;
    logic [3:0]  data_ram_wen;
    logic [4:0]  rf_waddr;

    assign ex_pc        = id_ex_q[158:127];
    assign inst         = id_ex_q[126:95];
    assign alu_op       = id_ex_q[94:83];
    assign sel_alu_src1 = id_ex_q[82:80];
    assign sel_alu_src2 = id_ex_q[79:76];
    assign data_ram_en  = id_ex_q[75];
    assign data_ram_wen = id_ex_q[74:71];
    assign rf_we        = id_ex_q[70];
    assign rf_waddr     = id_ex_q[69:65];
    assign sel_rf_res   = id_ex_q[64];
    assign rdata1       = id_ex_q[63:32];
    assign rdata2       = id_ex_q[31:0];

    // Special (opcode 0) decode
    logic special;
    logic is_div, is_divu, is_mult, is_multu, is_mfhi, is_mflo, is_mthi, is_mtlo;
    assign special  = (inst[31:26] == 6'd0);
    assign is_div   = special && inst[5:0] == 6'h1A;
    assign is_divu  = special && inst[5:0] == 6'h1B;
    assign is_mult  = special && inst[5:0] == 6'h18;
    assign is_multu = special && inst[5:0] == 6'h19;
    assign is_mfhi  = special && inst[5:0] == 6'h10;
    assign is_mflo  = special && inst[5:0] == 6'h12;
    assign is_mthi  = special && inst[5:0] == 6'h11;
    assign is_mtlo  = special && inst[5:0] == 6'h13;

    // Operand select: one-hot AND-OR mux, all-zero select yields 0
    logic [31:0] src1, src2;
    assign src1 = ({32{sel_alu_src1[0]}} & rdata1)
                | ({32{sel_alu_src1[1]}} & ex_pc)
                | ({32{sel_alu_src1[2]}} & {27'd0, inst[10:6]});
    assign src2 = ({32{sel_alu_src2[0]}} & rdata2)
                | ({32{sel_alu_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
                | ({32{sel_alu_src2[2]}} & 32'd8)
                | ({32{sel_alu_src2[3]}} & {16'd0, inst[15:0]});

    // ALU: op vector MSB first = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui
    logic [31:0] sra_res, alu_result;
    assign sra_res = $signed(src2) >>> src1[4:0];
    assign alu_result =
          ({32{alu_op[11]}} & (src1 + src2))
        | ({32{alu_op[10]}} & (src1 - src2))
        | ({32{alu_op[9]}}  & {31'd0, $signed(src1) < $signed(src2)})
        | ({32{alu_op[8]}}  & {31'd0, src1 < src2})
        | ({32{alu_op[7]}}  & (src1 & src2))
        | ({32{alu_op[6]}}  & ~(src1 | src2))
        | ({32{alu_op[5]}}  & (src1 | src2))
        | ({32{alu_op[4]}}  & (src1 ^ src2))
        | ({32{alu_op[3]}}  & (src2 << src1[4:0]))
        | ({32{alu_op[2]}}  & (src2 >> src1[4:0]))
        | ({32{alu_op[1]}}  & sra_res)
        | ({32{alu_op[0]}}  & {src2[15:0], 16'd0});

    logic [31:0] hi_q, lo_q, ex_result;
    assign ex_result = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_result);

    assign bus.ex_to_mem_bus   = {ex_pc, data_ram_en, data_ram_wen, sel_rf_res,
                                  rf_we, rf_waddr, ex_result};
    assign bus.ex_to_id_bus    = {rf_we, rf_waddr, ex_result};
    assign bus.data_sram_en    = data_ram_en;
    assign bus.data_sram_wen   = data_ram_wen;
    assign bus.data_sram_addr  = alu_result;
    assign bus.data_sram_wdata = rdata2;

    // Divider FSM
    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;
    div_state_t div_state_q, div_state_d;

    logic [5:0]  div_cnt_q;
    logic [31:0] div_rem_q, div_quo_q, div_dsr_q, div_rs_q;
    logic        div_neg_q_q, div_neg_r_q, div_zero_q;
    logic        start_div, div_signed;

    assign div_signed = is_div;
    assign start_div  = is_div || is_divu;

    always_comb begin
        div_state_d         = div_state_q;
        bus.stallreq_for_ex = 1'b0;
        case (div_state_q)
            DIV_IDLE: begin
                if (start_div) begin
                    bus.stallreq_for_ex = 1'b1;
                    div_state_d         = DIV_RUN;
                end
            end
            DIV_RUN: begin
                bus.stallreq_for_ex = 1'b1;
                if (div_cnt_q == 6'(DIV_CYCLES - 1)) begin
                    div_state_d = DIV_DONE;
                end
            end
            DIV_DONE: div_state_d = DIV_IDLE;
            default:  div_state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_state_q <= DIV_IDLE;
        end else begin
            div_state_q <= div_state_d;
        end
    end

    // Restoring step: shift next dividend bit into the partial remainder,
    // subtract the divisor when it fits (bit 32 of the difference is the borrow).
    logic [32:0] partial, diff;
    logic [31:0] rem_next, quo_next;
    assign partial = {div_rem_q, div_quo_q[31]};
    assign diff    = partial - {1'b0, div_dsr_q};
    assign rem_next = diff[32] ? partial[31:0] : diff[31:0];
    assign quo_next = {div_quo_q[30:0], ~diff[32]};

    logic [31:0] rs_abs, rt_abs;
    assign rs_abs = (div_signed && rdata1[31]) ? (32'd0 - rdata1) : rdata1;
    assign rt_abs = (div_signed && rdata2[31]) ? (32'd0 - rdata2) : rdata2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q   <= '0;
            div_rem_q   <= '0;
            div_quo_q   <= '0;
            div_dsr_q   <= '0;
            div_rs_q    <= '0;
            div_neg_q_q <= 1'b0;
            div_neg_r_q <= 1'b0;
            div_zero_q  <= 1'b0;
        end else if (div_state_q == DIV_IDLE && start_div) begin
            div_cnt_q   <= '0;
            div_rem_q   <= '0;
            div_quo_q   <= rs_abs;
            div_dsr_q   <= rt_abs;
            div_rs_q    <= rdata1;
            div_neg_q_q <= div_signed && (rdata1[31] ^ rdata2[31]);
            div_neg_r_q <= div_signed && rdata1[31];
            div_zero_q  <= (rdata2 == 32'd0);
        end else if (div_state_q == DIV_RUN) begin
            div_cnt_q <= div_cnt_q + 6'd1;
            div_rem_q <= rem_next;
            div_quo_q <= quo_next;
        end
    end

    // Divide by zero bypasses the sign fixup and returns the raw dividend in HI.
    logic [31:0] quo_final, rem_final;
    assign quo_final = div_zero_q  ? 32'hFFFF_FFFF :
                       div_neg_q_q ? (32'd0 - div_quo_q) : div_quo_q;
    assign rem_final = div_zero_q  ? div_rs_q :
                       div_neg_r_q ? (32'd0 - div_rem_q) : div_rem_q;

`ifdef EX_MULT_EN
    logic [63:0] mul_a, mul_b, mul_p;
    assign mul_a = is_mult ? {{32{rdata1[31]}}, rdata1} : {32'd0, rdata1};
    assign mul_b = is_mult ? {{32{rdata2[31]}}, rdata2} : {32'd0, rdata2};
    assign mul_p = mul_a * mul_b;
`endif

    // HI/LO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (div_state_q == DIV_DONE) begin
            lo_q <= quo_final;
            hi_q <= rem_final;
`ifdef EX_MULT_EN
        end else if ((is_mult || is_multu) && bus.stall[2] != STOP) begin
            hi_q <= mul_p[63:32];
            lo_q <= mul_p[31:0];
`endif
        end else begin
            if (is_mthi) hi_q <= rdata1;
            if (is_mtlo) lo_q <= rdata1;
        end
    end

    logic unused_bits;
`ifdef EX_MULT_EN
    assign unused_bits = ^{bus.stall[5:4], bus.stall[1:0], inst[25:16]};
`else
    assign unused_bits = ^{bus.stall[5:4], bus.stall[1:0], inst[25:16], is_mult, is_multu};
`endif
endmodule
